// File: rtl/sweep_ctrl_pkg.sv
// sweep_ctrl_pkg: shared FSM state type and step helper for the sweep controller
package sweep_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_TURN  = 3'd3,
    S_DONE  = 3'd4
`ifdef SWEEP_DWELL_EN
    , S_DWELL = 3'd5
`endif
  } sweep_state_t;
  function automatic logic [3:0] step_nz(input logic [3:0] s);
    return s == 4'd0 ? 4'd1 : s;
  endfunction
endpackage

// File: rtl/sweep_bound_chk.sv
// sweep_bound_chk: turn condition for the next counter step, in WIDTH+1 bits so nothing wraps
//  count/step/up/finish in, turn out (high when the next step would leave [MIN,MAX] or the far endpoint is reached)
module sweep_bound_chk #(
  parameter int WIDTH = 8,
  parameter int MAX   = 100,
  parameter int MIN   = 10
) (
  input  logic [WIDTH-1:0] count,
  input  logic [3:0]       step,
  input  logic             up,
  input  logic             finish,
  output logic             turn
);
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] MIN_X = (WIDTH+1)'(MIN);
  logic [WIDTH:0] count_x, step_x;
  assign count_x = {1'b0, count};
  assign step_x  = (WIDTH+1)'(step);
  // finish is only honoured at the far endpoint, so the start endpoint right after a load is ignored
  always_comb turn = up ? (count_x + step_x > MAX_X) || (finish && count_x == MAX_X)
                        : (count_x < MIN_X + step_x) || (finish && count_x == MIN_X);
endmodule

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: sequences a bounded up/down counter through a programmed number of half-sweeps
//  in : clk, rst, start, stop, cfg_sweeps, cfg_din, cfg_step, cnt_count, cnt_finish
//  out: busy, done, err, aborted, sweeps_done, cnt_en, cnt_set, cnt_din, cnt_step, cnt_up_down
//  SWEEP_DWELL_EN: when defined, hold the counter for DWELL cycles after every non-final turn
module sweep_ctrl
  import sweep_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX      = 100,
  parameter int MIN      = 10,
  parameter int NSWEEP_W = 8
`ifdef SWEEP_DWELL_EN
  , parameter int DWELL  = 4
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [NSWEEP_W-1:0] cfg_sweeps,
  input  logic [3:0]          cfg_din,
  input  logic [3:0]          cfg_step,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                aborted,
  output logic [NSWEEP_W-1:0] sweeps_done,
  output logic                cnt_en,
  output logic                cnt_set,
  output logic [3:0]          cnt_din,
  output logic [3:0]          cnt_step,
  output logic                cnt_up_down,
  input  logic [WIDTH-1:0]    cnt_count,
  input  logic                cnt_finish
);
  sweep_state_t state;
  logic [3:0] din_l, step_l;
  logic [NSWEEP_W-1:0] sweeps_l;
  logic turn, bad, last;
`ifdef SWEEP_DWELL_EN
  localparam int DW_W = $clog2(DWELL + 1);
  logic [DW_W-1:0] dw_cnt;
`endif
  sweep_bound_chk #(.WIDTH(WIDTH), .MAX(MAX), .MIN(MIN)) u_chk (
    .count(cnt_count), .step(step_l), .up(cnt_up_down), .finish(cnt_finish), .turn(turn)
  );
  assign bad = (32'(cfg_din) < 32'(MIN)) || (32'(cfg_din) > 32'(MAX));
  assign last = sweeps_done + 1'b1 == sweeps_l;
  assign cnt_set  = state == S_LOAD;
  assign cnt_din  = din_l;
  assign cnt_step = step_l;
  // the counter is stopped in the same cycle a turn or stop is seen, so it never overshoots
  always_comb cnt_en = (state == S_LOAD) || (state == S_RUN && !turn && !stop);
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      aborted     <= 1'b0;
      sweeps_done <= '0;
      din_l       <= '0;
      step_l      <= '0;
      sweeps_l    <= '0;
      cnt_up_down <= 1'b1;
`ifdef SWEEP_DWELL_EN
      dw_cnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          din_l       <= cfg_din;
          step_l      <= step_nz(cfg_step);
          sweeps_l    <= cfg_sweeps;
          sweeps_done <= '0;
          err         <= bad;
          aborted     <= 1'b0;
          cnt_up_down <= 1'b1;
          busy        <= 1'b1;
          state       <= (bad || cfg_sweeps == '0) ? S_DONE : S_LOAD;
          done        <= bad || cfg_sweeps == '0;
        end
        S_LOAD: state <= S_RUN;
        S_RUN: if (stop) begin
          state   <= S_DONE;
          done    <= 1'b1;
          aborted <= 1'b1;
        end else if (turn) state <= S_TURN;
        S_TURN: if (stop) begin
          state   <= S_DONE;
          done    <= 1'b1;
          aborted <= 1'b1;
        end else begin
          sweeps_done <= &sweeps_done ? sweeps_done : sweeps_done + 1'b1;
          cnt_up_down <= ~cnt_up_down;
          done        <= last;
`ifdef SWEEP_DWELL_EN
          dw_cnt      <= DW_W'(DWELL - 1);
          state       <= last ? S_DONE : S_DWELL;
`else
          state       <= last ? S_DONE : S_RUN;
`endif
        end
`ifdef SWEEP_DWELL_EN
        S_DWELL: if (stop) begin
          state   <= S_DONE;
          done    <= 1'b1;
          aborted <= 1'b1;
        end else if (dw_cnt == '0) state <= S_RUN;
        else dw_cnt <= dw_cnt - 1'b1;
`endif
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed bench for sweep_ctrl with a behavioural bounded counter attached
module tb_sweep_ctrl;
`ifdef SWEEP_DWELL_EN
  localparam int DW_EXTRA = 4;
`else
  localparam int DW_EXTRA = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [7:0] cfg_sweeps = '0;
  logic [3:0] cfg_din = '0, cfg_step = '0;
  logic busy, done, err, aborted, cnt_en, cnt_set, cnt_up_down, cnt_finish;
  logic [7:0] sweeps_done, count = '0;
  logic [3:0] cnt_din, cnt_step;
  logic oor = 1'b0;
  int checks = 0, failures = 0, en_cnt = 0;

  always #5 clk = ~clk;

  sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_sweeps(cfg_sweeps), .cfg_din(cfg_din),
    .cfg_step(cfg_step), .busy(busy), .done(done), .err(err), .aborted(aborted),
    .sweeps_done(sweeps_done), .cnt_en(cnt_en), .cnt_set(cnt_set), .cnt_din(cnt_din),
    .cnt_step(cnt_step), .cnt_up_down(cnt_up_down), .cnt_count(count), .cnt_finish(cnt_finish)
  );

  // bounded counter model: saturates at 10/100, finish at either endpoint
  logic [8:0] up_v, lo_v;
  assign up_v = {1'b0, count} + {5'b0, cnt_step};
  assign lo_v = 9'd10 + {5'b0, cnt_step};
  assign cnt_finish = count == 8'd10 || count == 8'd100;
  always @(posedge clk) begin
    if (cnt_en) begin
      if (cnt_set) count <= {4'b0, cnt_din};
      else if (cnt_up_down) count <= up_v > 9'd100 ? 8'd100 : up_v[7:0];
      else count <= {1'b0, count} < lo_v ? 8'd10 : count - {4'b0, cnt_step};
    end
    if (cnt_en) en_cnt <= en_cnt + 1;
  end
  always @(negedge clk) if (count != 8'd0 && (count < 8'd10 || count > 8'd100)) oor = 1'b1;

  task automatic run_start(input logic [7:0] sw, input logic [3:0] din, input logic [3:0] st);
    @(negedge clk);
    cfg_sweeps = sw; cfg_din = din; cfg_step = st; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, input int inj, output int n);
    n = 0;
    while (done !== 1'b1 && n < lim) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = (n == inj);
      if (n == inj) begin cfg_sweeps = 8'd1; cfg_din = 4'd12; cfg_step = 4'd5; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, done, err, aborted, cnt_en, cnt_set} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {busy, done, err, aborted, cnt_en, cnt_set}); end
    checks++; if (cnt_up_down !== 1'b1) begin failures++; $display("FAIL reset_up_down got=%b exp=1", cnt_up_down); end
    checks++; if ({sweeps_done, cnt_din, cnt_step} !== 16'h0) begin failures++; $display("FAIL reset_values got=%h exp=0000", {sweeps_done, cnt_din, cnt_step}); end
    rst = 1'b0;
  endtask

  task automatic test_full_sweep;
    int n;
    run_start(8'd2, 4'd10, 4'd1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sweep_busy got=%b exp=1", busy); end
    wait_done(400, -1, n);
    checks++; if (n !== 185 + DW_EXTRA) begin failures++; $display("FAIL sweep_latency got=%0d exp=%0d", n, 185 + DW_EXTRA); end
    checks++; if (sweeps_done !== 8'd2) begin failures++; $display("FAIL sweep_count got=%0d exp=2", sweeps_done); end
    checks++; if ({err, aborted} !== 2'b00) begin failures++; $display("FAIL sweep_err_abort got=%b exp=00", {err, aborted}); end
    checks++; if (count !== 8'd10) begin failures++; $display("FAIL sweep_final_count got=%0d exp=10", count); end
    checks++; if (oor !== 1'b0) begin failures++; $display("FAIL sweep_range got=%b exp=0", oor); end
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL sweep_idle got=%b exp=00", {done, busy}); end
  endtask

  task automatic test_step7;
    int n;
    run_start(8'd1, 4'd10, 4'd7);
    wait_done(100, -1, n);
    checks++; if (n !== 15) begin failures++; $display("FAIL step7_latency got=%0d exp=15", n); end
    checks++; if (count !== 8'd94) begin failures++; $display("FAIL step7_count got=%0d exp=94", count); end
    checks++; if (cnt_up_down !== 1'b0) begin failures++; $display("FAIL step7_dir got=%b exp=0", cnt_up_down); end
    @(negedge clk);
  endtask

  task automatic test_step0;
    int n;
    run_start(8'd1, 4'd15, 4'd0);
    checks++; if (cnt_step !== 4'd1) begin failures++; $display("FAIL step0_step got=%0d exp=1", cnt_step); end
    wait_done(200, -1, n);
    checks++; if (n !== 88) begin failures++; $display("FAIL step0_latency got=%0d exp=88", n); end
    checks++; if (count !== 8'd100) begin failures++; $display("FAIL step0_count got=%0d exp=100", count); end
    @(negedge clk);
  endtask

  task automatic test_bad_din;
    int n, e0;
    e0 = en_cnt;
    run_start(8'd3, 4'd5, 4'd1);
    wait_done(4, -1, n);
    checks++; if (done !== 1'b1 || n > 1) begin failures++; $display("FAIL bad_done got=%b@%0d exp=1@<=1", done, n); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL bad_err got=%b exp=1", err); end
    checks++; if (en_cnt !== e0) begin failures++; $display("FAIL bad_en got=%0d exp=%0d", en_cnt, e0); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bad_idle got=%b exp=0", busy); end
  endtask

  task automatic test_stop;
    int k = 0;
    run_start(8'd2, 4'd10, 4'd1);
    while (count !== 8'd50 && k < 200) begin @(negedge clk); k++; end
    checks++; if (count !== 8'd50) begin failures++; $display("FAIL stop_reach got=%0d exp=50", count); end
    stop = 1'b1;
    #1;
    checks++; if (cnt_en !== 1'b0) begin failures++; $display("FAIL stop_en got=%b exp=0", cnt_en); end
    @(negedge clk);
    stop = 1'b0;
    checks++; if ({done, aborted} !== 2'b11) begin failures++; $display("FAIL stop_done got=%b exp=11", {done, aborted}); end
    @(negedge clk);
    checks++; if (count !== 8'd50 || busy !== 1'b0) begin failures++; $display("FAIL stop_hold got=%0d/%b exp=50/0", count, busy); end
  endtask

  task automatic test_reset_mid_run;
    int n, k = 0;
    logic [7:0] c0;
    run_start(8'd2, 4'd10, 4'd1);
    while (count !== 8'd30 && k < 200) begin @(negedge clk); k++; end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, err, aborted, cnt_en, cnt_set, cnt_up_down} !== 7'b0000001) begin failures++; $display("FAIL rst_run_flags got=%b exp=0000001", {busy, done, err, aborted, cnt_en, cnt_set, cnt_up_down}); end
    checks++; if ({sweeps_done, cnt_din, cnt_step} !== 16'h0) begin failures++; $display("FAIL rst_run_values got=%h exp=0000", {sweeps_done, cnt_din, cnt_step}); end
    c0 = count;
    repeat (3) @(negedge clk);
    checks++; if (count !== c0) begin failures++; $display("FAIL rst_run_frozen got=%0d exp=%0d", count, c0); end
    rst = 1'b0;
    run_start(8'd1, 4'd12, 4'd3);
    wait_done(100, -1, n);
    checks++; if (n !== 32 || count !== 8'd99) begin failures++; $display("FAIL rst_fresh got=%0d/%0d exp=32/99", n, count); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n;
    run_start(8'd3, 4'd10, 4'd2);
    wait_done(400, 20, n);
    checks++; if (n !== 142 + 2 * DW_EXTRA) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", n, 142 + 2 * DW_EXTRA); end
    checks++; if (sweeps_done !== 8'd3 || count !== 8'd100) begin failures++; $display("FAIL b2b_result got=%0d/%0d exp=3/100", sweeps_done, count); end
    checks++; if (cnt_up_down !== 1'b0 || cnt_step !== 4'd2) begin failures++; $display("FAIL b2b_cfg got=%b/%0d exp=0/2", cnt_up_down, cnt_step); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_step7();
    test_step0();
    test_bad_din();
    test_stop();
    test_reset_mid_run();
    test_back_to_back();
    checks++; if (oor !== 1'b0) begin failures++; $display("FAIL range_overall got=%b exp=0", oor); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
